gfx_rom_slot_responder: RTL and testbench

//  SDRAM-side responder for GFX ROM read ports (sprite, SCR0, SCR1, SCR2) driven by the bank/decode chip.

---
 rtl/gfx_rom_slot_responder_pkg.sv | 14 +
 rtl/gfx_rom_slot_responder_arb.sv | 33 +++
 rtl/gfx_rom_slot_responder.sv | 183 ++++++++++++++++++
 tb/tb_gfx_rom_slot_responder.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_rom_slot_responder_pkg.sv
// Shared types for the GFX ROM slot responder: FSM encoding and SDRAM beat/word widths.
package gfx_rom_slot_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BEAT0 = 2'd2,
        ST_BEAT1 = 2'd3
    } slot_state_t;

    localparam int BEAT_W = 16;
    localparam int WORD_W = 32;

endpackage

// File: rtl/gfx_rom_slot_responder_arb.sv
// Round-robin arbiter: picks the first missing port after rr_last_s, wrapping modulo NPORTS.
module gfx_rr_arbiter #(
    parameter int NPORTS = 4,
    parameter int IW     = $clog2(NPORTS)
) (
    input  logic [NPORTS-1:0] miss_vec_s,
    input  logic [IW-1:0]     rr_last_s,
    output logic [NPORTS-1:0] gnt_oh_s,
    output logic [IW-1:0]     gnt_idx_s,
    output logic              gnt_any_s
);

    int idx_v;

    // Rotating priority search starting one past the last served port
    always_comb begin
        gnt_oh_s  = '0;
        gnt_idx_s = '0;
        gnt_any_s = 1'b0;
        idx_v     = 0;
        for (int i = 1; i <= NPORTS; i++) begin
            idx_v = (int'(rr_last_s) + i) % NPORTS;
            if (!gnt_any_s && miss_vec_s[idx_v]) begin
                gnt_oh_s[idx_v] = 1'b1;
                gnt_idx_s       = idx_v[IW-1:0];
                gnt_any_s       = 1'b1;
            end else begin
                gnt_any_s = gnt_any_s;
            end
        end
    end

endmodule

// File: rtl/gfx_rom_slot_responder.sv
// SDRAM-side responder for the GFX ROM read ports: per-port last-word cache,
// round-robin miss arbitration and two-beat 16-bit SDRAM read assembly.
module gfx_rom_slot_responder
    import gfx_rom_slot_responder_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int AW     = 22,
    parameter int SAW    = 23
) (
    input  logic                 CLK96,
    input  logic                 RESET96_N,
    input  logic                 DOWNLOAD,
    input  logic [NPORTS-1:0]    REQ_CS,
    input  logic [NPORTS*AW-1:0] REQ_ADDR,
    output logic [NPORTS-1:0]    REQ_OK,
    output logic [NPORTS*32-1:0] REQ_DOUT,
    output logic                 SDRAM_RD,
    output logic [SAW-1:0]       SDRAM_ADDR,
    input  logic                 SDRAM_ACK,
    input  logic                 SDRAM_RDY,
    input  logic [15:0]          SDRAM_DIN
);

    localparam int IW = $clog2(NPORTS);

    slot_state_t                    state_r, state_s;
    logic [IW-1:0]                  rr_last_r;
    logic [IW-1:0]                  gnt_port_r, gnt_port_s;
    logic [NPORTS-1:0]              gnt_oh_r, gnt_oh_s;
    logic [AW-1:0]                  gnt_addr_r, gnt_addr_s;
    logic [BEAT_W-1:0]              low_r, low_s;
    logic                           rd_r, rd_s;
    logic [SAW-1:0]                 sd_addr_r, sd_addr_s;
    logic                           fill_s;

    logic [NPORTS-1:0][AW-1:0]      req_addr_s;
    logic [NPORTS-1:0][AW-1:0]      tag_r;
    logic [NPORTS-1:0][WORD_W-1:0]  data_r;
    logic [NPORTS-1:0]              valid_r;
    logic [NPORTS-1:0]              hit_s;
    logic [NPORTS-1:0]              miss_s;
    logic [NPORTS-1:0]              ok_r;

    logic [NPORTS-1:0]              arb_oh_s;
    logic [IW-1:0]                  arb_idx_s;
    logic                           arb_any_s;

    // Packed 2-D view has the same bit layout as the flat address bus
    assign req_addr_s = REQ_ADDR;

    // Cache lookup against the requester's current address
    always_comb begin
        hit_s = '0;
        for (int p = 0; p < NPORTS; p++) begin
            hit_s[p] = valid_r[p] && (tag_r[p] == req_addr_s[p]);
        end
        miss_s = REQ_CS & ~hit_s;
    end

    gfx_rr_arbiter #(
        .NPORTS (NPORTS),
        .IW     (IW)
    ) u_arb (
        .miss_vec_s (miss_s),
        .rr_last_s  (rr_last_r),
        .gnt_oh_s   (arb_oh_s),
        .gnt_idx_s  (arb_idx_s),
        .gnt_any_s  (arb_any_s)
    );

    // Next-state and SDRAM handshake decode
    always_comb begin
        state_s    = state_r;
        rd_s       = rd_r;
        sd_addr_s  = sd_addr_r;
        gnt_port_s = gnt_port_r;
        gnt_oh_s   = gnt_oh_r;
        gnt_addr_s = gnt_addr_r;
        low_s      = low_r;
        fill_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!DOWNLOAD && arb_any_s) begin
                    gnt_port_s = arb_idx_s;
                    gnt_oh_s   = arb_oh_s;
                    gnt_addr_s = req_addr_s[arb_idx_s];
                    rd_s       = 1'b1;
                    sd_addr_s  = SAW'({req_addr_s[arb_idx_s], 1'b0});
                    state_s    = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (SDRAM_ACK) begin
                    rd_s    = 1'b0;
                    state_s = ST_BEAT0;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_BEAT0: begin
                if (SDRAM_RDY) begin
                    low_s   = SDRAM_DIN;
                    state_s = ST_BEAT1;
                end else begin
                    state_s = ST_BEAT0;
                end
            end
            ST_BEAT1: begin
                if (SDRAM_RDY) begin
                    fill_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BEAT1;
                end
            end
            default: begin
                rd_s    = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM, grant and SDRAM request registers
    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            state_r    <= ST_IDLE;
            rd_r       <= 1'b0;
            sd_addr_r  <= '0;
            gnt_port_r <= '0;
            gnt_oh_r   <= '0;
            gnt_addr_r <= '0;
            low_r      <= '0;
            rr_last_r  <= IW'(NPORTS - 1);
        end else begin
            state_r    <= state_s;
            rd_r       <= rd_s;
            sd_addr_r  <= sd_addr_s;
            gnt_port_r <= gnt_port_s;
            gnt_oh_r   <= gnt_oh_s;
            gnt_addr_r <= gnt_addr_s;
            low_r      <= low_s;
            rr_last_r  <= fill_s ? gnt_port_r : rr_last_r;
        end
    end

    // Cache fill; a ROM download flushes every entry and swallows any fill
    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            valid_r <= '0;
            tag_r   <= '0;
            data_r  <= '0;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (DOWNLOAD) begin
                    valid_r[p] <= 1'b0;
                end else if (fill_s && gnt_oh_r[p]) begin
                    valid_r[p] <= 1'b1;
                    tag_r[p]   <= gnt_addr_r;
                    data_r[p]  <= {SDRAM_DIN, low_r};
                end else begin
                    valid_r[p] <= valid_r[p];
                end
            end
        end
    end

    // OK uses the pre-edge cache so it rises one edge after the fill
    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            ok_r <= '0;
        end else begin
            ok_r <= REQ_CS & hit_s & {NPORTS{~DOWNLOAD}};
        end
    end

    assign REQ_OK     = ok_r;
    assign REQ_DOUT   = data_r;
    assign SDRAM_RD   = rd_r;
    assign SDRAM_ADDR = sd_addr_r;

endmodule

// File: tb/tb_gfx_rom_slot_responder.sv
// Directed plus randomized bench for gfx_rom_slot_responder with a transaction-level reference model.
module tb_gfx_rom_slot_responder;

    localparam int NP  = 4;
    localparam int AW  = 22;
    localparam int SAW = 23;

    logic              CLK96     = 1'b0;
    logic              RESET96_N = 1'b0;
    logic              DOWNLOAD  = 1'b0;
    logic [NP-1:0]     REQ_CS    = '0;
    logic [NP*AW-1:0]  REQ_ADDR;
    logic [NP-1:0]     REQ_OK;
    logic [NP*32-1:0]  REQ_DOUT;
    logic              SDRAM_RD;
    logic [SAW-1:0]    SDRAM_ADDR;
    logic              SDRAM_ACK = 1'b0;
    logic              SDRAM_RDY = 1'b0;
    logic [15:0]       SDRAM_DIN = 16'h0000;

    logic [AW-1:0]     addr_v [NP];

    gfx_rom_slot_responder #(.NPORTS(NP), .AW(AW), .SAW(SAW)) dut (
        .CLK96      (CLK96),
        .RESET96_N  (RESET96_N),
        .DOWNLOAD   (DOWNLOAD),
        .REQ_CS     (REQ_CS),
        .REQ_ADDR   (REQ_ADDR),
        .REQ_OK     (REQ_OK),
        .REQ_DOUT   (REQ_DOUT),
        .SDRAM_RD   (SDRAM_RD),
        .SDRAM_ADDR (SDRAM_ADDR),
        .SDRAM_ACK  (SDRAM_ACK),
        .SDRAM_RDY  (SDRAM_RDY),
        .SDRAM_DIN  (SDRAM_DIN)
    );

    always #5 CLK96 = ~CLK96;

    always_comb begin
        REQ_ADDR = '0;
        for (int p = 0; p < NP; p++) begin
            REQ_ADDR[p*AW +: AW] = addr_v[p];
        end
    end

    int checks = 0;
    int errors = 0;

    // reference model: cache contents and transaction progress
    bit            m_valid [NP];
    logic [AW-1:0] m_tag   [NP];
    logic [31:0]   m_data  [NP];
    int            m_rr;
    int            m_phase;
    int            m_gnt;
    logic [AW-1:0] m_gaddr;
    logic [NP-1:0] m_ok;
    bit            m_rd;

    // SDRAM responder state
    int             r_state, r_wait, r_beat;
    logic [SAW-1:0] r_addr;
    int             ack_dly = 0;
    int             rdy_dly = 0;
    bit             rnd_mode = 1'b0;
    logic [AW-1:0]  grant_log [$];

    function automatic logic [15:0] mem16(input logic [SAW-1:0] a);
        logic [31:0] h;
        if (a == 23'h000246) return 16'hBEEF;
        if (a == 23'h000247) return 16'hDEAD;
        h = 32'(a) * 32'h9E3779B1;
        return h[31:16] ^ h[15:0];
    endfunction

    function automatic logic [31:0] mem32(input logic [AW-1:0] w);
        return {mem16({w, 1'b1}), mem16({w, 1'b0})};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) m_valid[p] = 1'b0;
        m_rr    = NP - 1;
        m_phase = 0;
        m_rd    = 1'b0;
        m_ok    = '0;
        r_state = 0;
        r_wait  = 0;
        r_beat  = 0;
    endtask

    task automatic drive_sdram();
        SDRAM_ACK = 1'b0;
        SDRAM_RDY = 1'b0;
        if (r_state == 0 && SDRAM_RD) begin
            r_state = 1;
            r_addr  = SDRAM_ADDR;
            if (rnd_mode) begin
                ack_dly = $urandom_range(0, 3);
                rdy_dly = $urandom_range(0, 2);
            end
            r_wait = ack_dly;
            grant_log.push_back(SDRAM_ADDR[SAW-1:1]);
        end
        if (r_state == 1) begin
            if (r_wait == 0) begin
                SDRAM_ACK = 1'b1;
                r_state   = 2;
                r_wait    = rdy_dly;
                r_beat    = 0;
            end else begin
                r_wait--;
            end
        end else if (r_state == 2) begin
            if (r_wait == 0) begin
                SDRAM_RDY = 1'b1;
                SDRAM_DIN = mem16(r_addr + SAW'(r_beat));
                r_beat++;
                r_wait = rdy_dly;
                if (r_beat == 2) r_state = 0;
            end else begin
                r_wait--;
            end
        end
        if (rnd_mode && !SDRAM_ACK && !SDRAM_RDY && r_state != 2 && $urandom_range(0, 7) == 0) begin
            SDRAM_RDY = 1'b1;
            SDRAM_DIN = 16'($urandom);
        end
    endtask

    task automatic model_edge();
        logic [NP-1:0] hit, miss;
        bit found, fill;
        int k;
        fill = 1'b0;
        for (int p = 0; p < NP; p++) hit[p] = m_valid[p] && (m_tag[p] == addr_v[p]);
        miss = REQ_CS & ~hit;
        m_ok = REQ_CS & hit & {NP{!DOWNLOAD}};
        case (m_phase)
            0: if (!DOWNLOAD && miss != '0) begin
                found = 1'b0;
                for (int i = 1; i <= NP; i++) begin
                    k = (m_rr + i) % NP;
                    if (!found && miss[k]) begin
                        found = 1'b1;
                        m_gnt = k;
                    end
                end
                m_gaddr = addr_v[m_gnt];
                m_rd    = 1'b1;
                m_phase = 1;
            end
            1: if (SDRAM_ACK) begin m_rd = 1'b0; m_phase = 2; end
            2: if (SDRAM_RDY) m_phase = 3;
            3: if (SDRAM_RDY) begin fill = 1'b1; m_rr = m_gnt; m_phase = 0; end
            default: m_phase = 0;
        endcase
        if (DOWNLOAD) begin
            for (int p = 0; p < NP; p++) m_valid[p] = 1'b0;
        end else if (fill) begin
            m_valid[m_gnt] = 1'b1;
            m_tag[m_gnt]   = m_gaddr;
            m_data[m_gnt]  = mem32(m_gaddr);
        end
    endtask

    task automatic compare();
        chk("sdram_rd", 64'(SDRAM_RD), 64'(m_rd));
        if (m_rd) chk("sdram_addr", 64'(SDRAM_ADDR), 64'({m_gaddr, 1'b0}));
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("ok%0d", p), 64'(REQ_OK[p]), 64'(m_ok[p]));
            if (m_ok[p]) chk($sformatf("dout%0d", p), 64'(REQ_DOUT[p*32 +: 32]), 64'(m_data[p]));
        end
    endtask

    task automatic step();
        drive_sdram();
        @(posedge CLK96);
        model_edge();
        #1;
        compare();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ok"}, 64'(REQ_OK), 64'd0);
        chk({tag, "_dout"}, 64'(REQ_DOUT), 64'd0);
        chk({tag, "_rd"}, 64'(SDRAM_RD), 64'd0);
        chk({tag, "_addr"}, 64'(SDRAM_ADDR), 64'd0);
    endtask

    task automatic cold_miss_123(input string tag);
        int n;
        addr_v[0] = 22'h000123;
        REQ_CS    = 4'b0001;
        ack_dly   = 0;
        rdy_dly   = 0;
        step();
        chk({tag, "_rd"}, 64'(SDRAM_RD), 64'd1);
        chk({tag, "_addr"}, 64'(SDRAM_ADDR), 64'h000246);
        n = 1;
        while (!REQ_OK[0] && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd5);
        chk({tag, "_dout"}, 64'(REQ_DOUT[31:0]), 64'hDEADBEEF);
    endtask

    initial begin
        int n;
        logic [AW-1:0] exp_a;
        for (int p = 0; p < NP; p++) addr_v[p] = '0;
        model_reset();
        #2;
        check_reset_outputs("reset");
        @(posedge CLK96);
        #1;
        RESET96_N = 1'b1;

        // 1: cold miss with minimum latency
        cold_miss_123("t1");

        // 2: cached re-request answers without SDRAM traffic
        REQ_CS = 4'b0000;
        step();
        REQ_CS = 4'b0001;
        step();
        chk("t2_ok", 64'(REQ_OK[0]), 64'd1);
        chk("t2_rd", 64'(SDRAM_RD), 64'd0);

        // 3: all ports miss together from reset rr_last
        RESET96_N = 1'b0;
        #1;
        model_reset();
        @(posedge CLK96);
        #1;
        RESET96_N = 1'b1;
        grant_log.delete();
        ack_dly = 1;
        rdy_dly = 1;
        for (int p = 0; p < NP; p++) addr_v[p] = 22'(32'h40 + p);
        REQ_CS = 4'b1111;
        n = 0;
        while (REQ_OK != 4'b1111 && n < 80) begin
            step();
            n++;
        end
        chk("t3_all_ok", 64'(REQ_OK), 64'hF);
        chk("t3_grants", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < NP && i < grant_log.size(); i++) begin
            exp_a = 22'(32'h40 + i);
            chk($sformatf("t3_order%0d", i), 64'(grant_log[i]), 64'(exp_a));
            chk($sformatf("t3_dout%0d", i), 64'(REQ_DOUT[i*32 +: 32]), 64'(mem32(exp_a)));
        end

        // 4: address change during BEAT0
        REQ_CS = 4'b0000;
        step();
        grant_log.delete();
        addr_v[2] = 22'h10;
        REQ_CS    = 4'b0100;
        ack_dly   = 0;
        rdy_dly   = 2;
        n = 0;
        while (m_phase != 2 && n < 10) begin
            step();
            n++;
        end
        addr_v[2] = 22'h20;
        n = 0;
        while (!REQ_OK[2] && n < 40) begin
            step();
            n++;
        end
        chk("t4_ok", 64'(REQ_OK[2]), 64'd1);
        chk("t4_grants", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() == 2) begin
            chk("t4_first", 64'(grant_log[0]), 64'h10);
            chk("t4_second", 64'(grant_log[1]), 64'h20);
        end
        chk("t4_dout", 64'(REQ_DOUT[2*32 +: 32]), 64'(mem32(22'h20)));

        // 5: DOWNLOAD during an in-flight request flushes and blocks grants
        REQ_CS = 4'b0000;
        step();
        addr_v[1] = 22'h55;
        REQ_CS    = 4'b0010;
        rdy_dly   = 0;
        n = 0;
        while (!REQ_OK[1] && n < 20) begin
            step();
            n++;
        end
        chk("t5_cached", 64'(REQ_OK[1]), 64'd1);
        addr_v[1] = 22'h66;
        ack_dly   = 3;
        step();
        DOWNLOAD  = 1'b1;
        step();
        grant_log.delete();
        addr_v[1] = 22'h55;
        repeat (11) step();
        chk("t5_rd_low", 64'(SDRAM_RD), 64'd0);
        chk("t5_no_grant", 64'(grant_log.size()), 64'd0);
        chk("t5_ok_low", 64'(REQ_OK), 64'd0);
        DOWNLOAD = 1'b0;
        n = 0;
        while (!REQ_OK[1] && n < 20) begin
            step();
            n++;
        end
        chk("t5_refetch_ok", 64'(REQ_OK[1]), 64'd1);
        chk("t5_refetch", 64'(grant_log.size()), 64'd1);
        if (grant_log.size() == 1) chk("t5_refetch_addr", 64'(grant_log[0]), 64'h55);

        // 6: reset asserted in BEAT1
        REQ_CS = 4'b0000;
        step();
        addr_v[0] = 22'h000123;
        REQ_CS    = 4'b0001;
        ack_dly   = 0;
        rdy_dly   = 2;
        n = 0;
        while (m_phase != 3 && n < 15) begin
            step();
            n++;
        end
        chk("t6_reach_beat1", 64'(n < 15), 64'd1);
        #2;
        RESET96_N = 1'b0;
        #1;
        check_reset_outputs("t6");
        model_reset();
        @(posedge CLK96);
        #1;
        RESET96_N = 1'b1;
        cold_miss_123("t6_cold");

        // randomized traffic with spurious RDY, random delays and DOWNLOAD pulses
        rnd_mode = 1'b1;
        REQ_CS   = 4'b0000;
        repeat (800) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 5) == 0) addr_v[p] = 22'($urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0) REQ_CS[p] = 1'($urandom);
            end
            if (!DOWNLOAD && $urandom_range(0, 60) == 0) DOWNLOAD = 1'b1;
            else if (DOWNLOAD && $urandom_range(0, 3) == 0) DOWNLOAD = 1'b0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
